// File: rtl/cpu_fetch_buffer.sv
// rtl/cpu_fetch_buffer.sv - in-order instruction fetch queue with branch flush
// Define FETCH_ADDR_CHECK_EN to block and report fetches from a misaligned PC.
module cpu_fetch_buffer #(
  parameter logic [31:0] RESET_VECTOR = 32'hbfc00000,
  parameter int          DEPTH        = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] ibus_addr,
  output logic        ibus_read,
  input  logic        ibus_ready,
  input  logic        ibus_rvalid,
  input  logic [31:0] ibus_rdata,
  input  logic        branch_valid,
  input  logic [31:0] branch_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        exr_valid,
  output logic [5:0]  exr_type,
  output logic [31:0] exr_a0
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_X = (CW+1)'(DEPTH);

  logic [31:0]      pc;
  logic [31:0]      ent_pc   [DEPTH];
  logic [31:0]      ent_inst [DEPTH];
  logic [DEPTH-1:0] ent_filled;
  logic [PW-1:0]    head_ptr;
  logic [PW-1:0]    tail_ptr;
  logic [PW-1:0]    fill_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    pend;
  logic [CW-1:0]    drop_cnt;
  logic [CW-1:0]    owed;
  logic [CW:0]      inflight;
  logic             pc_misaligned;
  logic             alloc;
  logic             fill;
  logic             drop;
  logic             pop;

  // Responses still owed by the bus include those already orphaned by a flush.
  assign inflight  = {1'b0, drop_cnt} + {1'b0, count};
  assign owed      = drop_cnt + pend;

  assign ibus_addr = pc;
  assign ibus_read = !reset && !pc_misaligned && !branch_valid && (inflight < DEPTH_X);

  assign out_valid = (count != '0) && ent_filled[head_ptr];
  assign out_inst  = ent_inst[head_ptr];
  assign out_pc    = ent_pc[head_ptr];

  assign alloc = ibus_read && ibus_ready;
  assign fill  = ibus_rvalid && (drop_cnt == '0) && (pend != '0);
  assign drop  = ibus_rvalid && (drop_cnt != '0);
  assign pop   = out_valid && out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc         <= RESET_VECTOR;
      head_ptr   <= '0;
      tail_ptr   <= '0;
      fill_ptr   <= '0;
      count      <= '0;
      pend       <= '0;
      drop_cnt   <= '0;
      ent_filled <= '0;
    end else if (branch_valid) begin
      pc         <= branch_addr;
      head_ptr   <= '0;
      tail_ptr   <= '0;
      fill_ptr   <= '0;
      count      <= '0;
      pend       <= '0;
      ent_filled <= '0;
      drop_cnt   <= owed - CW'(ibus_rvalid && (owed != '0));
    end else begin
      if (alloc) begin
        pc                   <= pc + 32'd4;
        tail_ptr             <= tail_ptr + PW'(1);
        ent_filled[tail_ptr] <= 1'b0;
      end
      if (fill) begin
        ent_filled[fill_ptr] <= 1'b1;
        fill_ptr             <= fill_ptr + PW'(1);
      end
      if (pop) begin
        ent_filled[head_ptr] <= 1'b0;
        head_ptr             <= head_ptr + PW'(1);
      end
      if (drop) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
      count <= count + CW'(alloc) - CW'(pop);
      pend  <= pend + CW'(alloc) - CW'(fill);
    end
  end

  always_ff @(posedge clock) begin
    if (alloc) begin
      ent_pc[tail_ptr] <= pc;
    end
    if (fill) begin
      ent_inst[fill_ptr] <= ibus_rdata;
    end
  end

`ifdef FETCH_ADDR_CHECK_EN
  localparam logic [5:0] CP0_EX_IF_ADDRERR = 6'd4;

  logic        exr_q;
  logic [31:0] exr_a0_q;

  assign pc_misaligned = (pc[1:0] != 2'b00);

  // Report only after older fetches have drained so the exception is precise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      exr_q    <= 1'b0;
      exr_a0_q <= '0;
    end else if (branch_valid) begin
      exr_q    <= 1'b0;
    end else if (pc_misaligned && (count == '0) && (drop_cnt == '0) && !exr_q) begin
      exr_q    <= 1'b1;
      exr_a0_q <= pc;
    end
  end

  assign exr_valid = exr_q;
  assign exr_type  = exr_q ? CP0_EX_IF_ADDRERR : 6'd0;
  assign exr_a0    = exr_a0_q;
`else
  assign pc_misaligned = 1'b0;
  assign exr_valid     = 1'b0;
  assign exr_type      = 6'd0;
  assign exr_a0        = 32'd0;
`endif

endmodule

// File: tb/tb_cpu_fetch_buffer.sv
// tb/tb_cpu_fetch_buffer.sv - directed checks for cpu_fetch_buffer
module tb_cpu_fetch_buffer;
  localparam logic [31:0] KEY = 32'h5a5a0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ibus_addr;
  logic        ibus_read;
  logic        ibus_ready = 1'b1;
  logic        ibus_rvalid = 1'b0;
  logic [31:0] ibus_rdata = 32'd0;
  logic        branch_valid = 1'b0;
  logic [31:0] branch_addr = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        exr_valid;
  logic [5:0]  exr_type;
  logic [31:0] exr_a0;

  int          total = 0;
  int          bad = 0;
  int          n_acc = 0;
  logic        resp_en = 1'b1;
  logic [31:0] bus_q [$];
  logic [31:0] popped;

  logic        s_read, s_acc, s_rv, s_ovalid, s_exv;
  logic [31:0] s_addr, s_opc, s_oinst, s_exa;
  logic [5:0]  s_ext;

  cpu_fetch_buffer dut (
    .clock(clock), .reset(reset),
    .ibus_addr(ibus_addr), .ibus_read(ibus_read), .ibus_ready(ibus_ready),
    .ibus_rvalid(ibus_rvalid), .ibus_rdata(ibus_rdata),
    .branch_valid(branch_valid), .branch_addr(branch_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .exr_valid(exr_valid), .exr_type(exr_type), .exr_a0(exr_a0)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock: in-order bus responder returns one word per cycle when enabled.
  task automatic cycle();
    if (resp_en && bus_q.size() != 0) begin
      ibus_rvalid = 1'b1;
      ibus_rdata  = bus_q[0] ^ KEY;
    end else begin
      ibus_rvalid = 1'b0;
      ibus_rdata  = 32'd0;
    end
    #1;
    s_read   = ibus_read;
    s_addr   = ibus_addr;
    s_acc    = ibus_read && ibus_ready;
    s_rv     = ibus_rvalid;
    s_ovalid = out_valid;
    s_opc    = out_pc;
    s_oinst  = out_inst;
    s_exv    = exr_valid;
    s_ext    = exr_type;
    s_exa    = exr_a0;
    @(posedge clock);
    if (s_rv) popped = bus_q.pop_front();
    if (s_acc) begin
      bus_q.push_back(s_addr);
      n_acc++;
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    ibus_rvalid  = 1'b0;
    ibus_rdata   = 32'd0;
    branch_valid = 1'b0;
    branch_addr  = 32'd0;
    ibus_ready   = 1'b1;
    out_ready    = 1'b1;
    resp_en      = 1'b1;
    @(negedge clock);
    @(negedge clock);
    bus_q.delete();
    n_acc = 0;
    reset = 1'b0;
  endtask

  initial begin
    bit found;

    // Outputs held while reset is asserted
    @(negedge clock);
    #1;
    chk1("rst_read", ibus_read, 1'b0);
    chk1("rst_ovalid", out_valid, 1'b0);
    chk1("rst_exv", exr_valid, 1'b0);
    chk("rst_ext", {26'd0, exr_type}, 32'd0);
    chk("rst_exa", exr_a0, 32'd0);
    chk("rst_addr", ibus_addr, 32'hbfc00000);

    // Streaming: one request and one instruction per cycle
    do_reset();
    for (int k = 0; k < 10; k++) begin
      cycle();
      chk1("s1_read", s_read, 1'b1);
      chk("s1_addr", s_addr, 32'hbfc00000 + 32'(4 * k));
      if (k >= 2) begin
        chk1("s1_ovalid", s_ovalid, 1'b1);
        chk("s1_opc", s_opc, 32'hbfc00000 + 32'(4 * (k - 2)));
        chk("s1_inst", s_oinst, (32'hbfc00000 + 32'(4 * (k - 2))) ^ KEY);
      end else begin
        chk1("s1_ovalid_early", s_ovalid, 1'b0);
      end
    end

    // Back-pressure: queue fills at DEPTH, first pop re-enables issue next cycle
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) cycle();
    chk("s2_accepted", 32'(n_acc), 32'd4);
    chk1("s2_blocked", s_read, 1'b0);
    out_ready = 1'b1;
    cycle();
    chk1("s2_pop_valid", s_ovalid, 1'b1);
    chk("s2_pop_pc", s_opc, 32'hbfc00000);
    chk1("s2_pop_read", s_read, 1'b0);
    cycle();
    chk1("s2_reissue_read", s_read, 1'b1);
    chk("s2_reissue_addr", s_addr, 32'hbfc00010);
    chk("s2_next_pc", s_opc, 32'hbfc00004);

    // Branch with three requests outstanding
    do_reset();
    resp_en = 1'b0;
    for (int k = 0; k < 3; k++) cycle();
    branch_valid = 1'b1;
    branch_addr  = 32'h80000100;
    cycle();
    chk1("s3_branch_read", s_read, 1'b0);
    branch_valid = 1'b0;
    resp_en      = 1'b1;
    cycle();
    chk1("s3_read", s_read, 1'b1);
    chk("s3_addr", s_addr, 32'h80000100);
    chk1("s3_no_stale", s_ovalid, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle();
      if (s_ovalid) begin
        found = 1'b1;
        chk("s3_first_pc", s_opc, 32'h80000100);
        chk("s3_first_inst", s_oinst, 32'h80000100 ^ KEY);
      end
    end
    chk1("s3_out_seen", found, 1'b1);

    // Branch coincident with a response and a pop
    do_reset();
    resp_en = 1'b0;
    for (int k = 0; k < 3; k++) cycle();
    ibus_ready = 1'b0;
    resp_en    = 1'b1;
    cycle();
    chk1("s4_pre_ovalid", s_ovalid, 1'b0);
    branch_valid = 1'b1;
    branch_addr  = 32'h80000200;
    cycle();
    chk1("s4_br_ovalid", s_ovalid, 1'b1);
    chk("s4_br_opc", s_opc, 32'hbfc00000);
    branch_valid = 1'b0;
    ibus_ready   = 1'b1;
    cycle();
    chk1("s4_c6_ovalid", s_ovalid, 1'b0);
    chk1("s4_c6_read", s_read, 1'b1);
    chk("s4_c6_addr", s_addr, 32'h80000200);
    cycle();
    chk1("s4_c7_ovalid", s_ovalid, 1'b0);
    cycle();
    chk1("s4_c8_ovalid", s_ovalid, 1'b1);
    chk("s4_c8_opc", s_opc, 32'h80000200);
    chk("s4_c8_inst", s_oinst, 32'h80000200 ^ KEY);

    // Asynchronous reset mid-burst with two requests outstanding
    do_reset();
    resp_en = 1'b0;
    cycle();
    cycle();
    #1;
    chk("s5_pre_addr", ibus_addr, 32'hbfc00008);
    #1;
    reset = 1'b1;
    #1;
    chk1("s5_read", ibus_read, 1'b0);
    chk("s5_addr", ibus_addr, 32'hbfc00000);
    chk1("s5_ovalid", out_valid, 1'b0);
    chk1("s5_exv", exr_valid, 1'b0);
    @(negedge clock);
    bus_q.delete();
    n_acc   = 0;
    resp_en = 1'b1;
    reset   = 1'b0;
    cycle();
    chk1("s5_rel_read", s_read, 1'b1);
    chk("s5_rel_addr", s_addr, 32'hbfc00000);

    // Misaligned branch target
    do_reset();
    branch_valid = 1'b1;
    branch_addr  = 32'h80000002;
    cycle();
    branch_valid = 1'b0;
    cycle();
    chk("s6_addr", s_addr, 32'h80000002);
`ifdef FETCH_ADDR_CHECK_EN
    chk1("s6_read", s_read, 1'b0);
    cycle();
    chk1("s6_exv", s_exv, 1'b1);
    chk("s6_ext", {26'd0, s_ext}, 32'd4);
    chk("s6_exa", s_exa, 32'h80000002);
    chk1("s6_hold_read", s_read, 1'b0);
`else
    chk1("s6_read", s_read, 1'b1);
    cycle();
    chk1("s6_exv", s_exv, 1'b0);
    chk("s6_ext", {26'd0, s_ext}, 32'd0);
    chk("s6_exa", s_exa, 32'd0);
`endif
    branch_valid = 1'b1;
    branch_addr  = 32'h80000004;
    cycle();
    branch_valid = 1'b0;
    cycle();
    chk1("s6_clr_exv", s_exv, 1'b0);
    chk1("s6_clr_read", s_read, 1'b1);
    chk("s6_clr_addr", s_addr, 32'h80000004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
